// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// decodes the supported instructions and drives datapath enables. Memory
// waits are bounded by a timeout that leads to a sticky TRAP state.
//
// Handshake: in FETCH and MEM the controller holds mem_req high until it sees
// mem_ready high on a rising clock edge. That edge completes the access, and
// the access enables (ir_we, mdr_we, store pc_we/retire) are asserted in that
// same cycle. mem_ready is ignored in every other state.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        aluout_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [2:0]  imm_sel,
    output logic        br_un,
    output logic        a_sel,
    output logic        b_sel,
    output logic [3:0]  alu_sel,
    output logic        reg_wen,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  cause,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_PASSB = 4'd7;

    localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(MEM_TIMEOUT);
    localparam bit               TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t           state_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       cause_q;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       b30;
    logic       unused_bits;

    logic       is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic       legal;
    logic       taken;
    logic [3:0] dec_alu;

    assign opcode      = instr[6:0];
    assign f3          = instr[14:12];
    assign b30         = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
    assign cnt_inc     = cnt + 1'b1;

    assign state = state_q;
    assign trap  = (state_q == S_TRAP);
    assign cause = cause_q;

    // Instruction decode: classify by opcode/func3/instr[30] and pick the ALU op
    always_comb begin
        is_r     = 1'b0;
        is_i     = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_br    = 1'b0;
        is_jal   = 1'b0;
        is_jalr  = 1'b0;
        is_lui   = 1'b0;
        is_auipc = 1'b0;
        dec_alu  = ALU_ADD;
        case (opcode)
            7'b0110011: begin
                is_r = 1'b1;
                case (f3)
                    3'b000:  dec_alu = b30 ? ALU_SUB : ALU_ADD;
                    3'b111:  dec_alu = ALU_AND;
                    3'b110:  dec_alu = ALU_OR;
                    3'b100:  dec_alu = ALU_XOR;
                    3'b010:  dec_alu = ALU_SLT;
                    3'b011:  dec_alu = ALU_SLTU;
                    default: is_r = 1'b0;
                endcase
                // instr[30] only selects SUB; on any other func3 it is illegal
                if (b30 && f3 != 3'b000) is_r = 1'b0;
            end
            7'b0010011: begin
                is_i = 1'b1;
                case (f3)
                    3'b000:  dec_alu = ALU_ADD;
                    3'b111:  dec_alu = ALU_AND;
                    3'b110:  dec_alu = ALU_OR;
                    3'b100:  dec_alu = ALU_XOR;
                    default: is_i = 1'b0;
                endcase
            end
            7'b0000011: is_lw    = (f3 == 3'b010);
            7'b0100011: is_sw    = (f3 == 3'b010);
            7'b1100011: is_br    = (f3 != 3'b010) && (f3 != 3'b011);
            7'b1101111: is_jal   = 1'b1;
            7'b1100111: is_jalr  = (f3 == 3'b000);
            7'b0110111: begin
                is_lui  = 1'b1;
                dec_alu = ALU_PASSB;
            end
            7'b0010111: is_auipc = 1'b1;
            default: ;
        endcase
        legal = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_jalr | is_lui | is_auipc;
    end

    // Branch resolution from the datapath comparator results
    always_comb begin
        case (f3)
            3'b000:         taken = br_eq;
            3'b001:         taken = !br_eq;
            3'b100, 3'b110: taken = br_lt;
            3'b101, 3'b111: taken = !br_lt;
            default:        taken = 1'b0;
        endcase
    end

    // Control FSM with the memory-wait timeout counter and trap cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt     <= '0;
            cause_q <= 2'b00;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        state_q <= S_DECODE;
                        cnt     <= '0;
                    end else if (TIMEOUT_EN && cnt_inc == TIMEOUT) begin
                        state_q <= S_TRAP;
                        cause_q <= 2'b10;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_DECODE: begin
                    cnt <= '0;
                    if (legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q <= S_TRAP;
                        cause_q <= 2'b01;
                    end
                end
                S_EXEC: begin
                    cnt <= '0;
                    if (is_br)              state_q <= S_FETCH;
                    else if (is_lw || is_sw) state_q <= S_MEM;
                    else                    state_q <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_q <= is_lw ? S_WB : S_FETCH;
                        cnt     <= '0;
                    end else if (TIMEOUT_EN && cnt_inc == TIMEOUT) begin
                        state_q <= S_TRAP;
                        cause_q <= 2'b11;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_WB: begin
                    cnt     <= '0;
                    state_q <= S_FETCH;
                end
                S_TRAP: cnt <= '0;
                default: begin
                    cnt     <= '0;
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Datapath controls decoded from state and instruction; writes gated by reset
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        mdr_we    = 1'b0;
        aluout_we = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        imm_sel   = 3'b000;
        br_un     = 1'b0;
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        alu_sel   = ALU_ADD;
        reg_wen   = 1'b0;
        wb_sel    = 2'b00;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXEC: begin
                aluout_we = 1'b1;
                alu_sel   = dec_alu;
                a_sel     = is_br | is_jal | is_auipc;
                b_sel     = !is_r;
                if (is_r)                     imm_sel = 3'b101;
                else if (is_sw)               imm_sel = 3'b001;
                else if (is_br)               imm_sel = 3'b010;
                else if (is_jal)              imm_sel = 3'b011;
                else if (is_lui || is_auipc)  imm_sel = 3'b100;
                else                          imm_sel = 3'b000;
                if (is_br) begin
                    br_un  = f3[1];
                    pc_we  = 1'b1;
                    pc_sel = taken;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_sw;
                if (mem_ready) begin
                    mdr_we = is_lw;
                    pc_we  = is_sw;
                    retire = is_sw;
                end
            end
            S_WB: begin
                reg_wen = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                pc_sel  = is_jal | is_jalr;
                if (is_lw)                 wb_sel = 2'b00;
                else if (is_jal || is_jalr) wb_sel = 2'b10;
                else                       wb_sel = 2'b01;
            end
            default: ;
        endcase
        if (!rst_n) begin
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            mdr_we  = 1'b0;
            reg_wen = 1'b0;
            mem_we  = 1'b0;
            retire  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instructions.
// For each instruction the reference model expands the mnemonic and chosen
// memory wait counts into the full expected cycle-by-cycle output trace.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    // Mnemonic ids, in table order
    localparam int M_ADD = 0,  M_SUB = 1,  M_AND = 2,  M_OR = 3,  M_XOR = 4;
    localparam int M_SLT = 5,  M_SLTU = 6, M_ADDI = 7, M_ANDI = 8, M_ORI = 9;
    localparam int M_XORI = 10, M_LW = 11, M_SW = 12,  M_BEQ = 13, M_BNE = 14;
    localparam int M_BLT = 15, M_BGE = 16, M_BLTU = 17, M_BGEU = 18, M_JAL = 19;
    localparam int M_JALR = 20, M_LUI = 21, M_AUIPC = 22, M_ILL = 23;

    localparam logic [31:0] RM = 32'hBFFF_8F80;
    localparam logic [31:0] IM = 32'hFFFF_8F80;
    localparam logic [31:0] UM = 32'hFFFF_FF80;

    logic [31:0] t_base [32] = '{
        32'h0000_0033, 32'h4000_0033, 32'h0000_7033, 32'h0000_6033,
        32'h0000_4033, 32'h0000_2033, 32'h0000_3033, 32'h0000_0013,
        32'h0000_7013, 32'h0000_6013, 32'h0000_4013, 32'h0000_2003,
        32'h0000_2023, 32'h0000_0063, 32'h0000_1063, 32'h0000_4063,
        32'h0000_5063, 32'h0000_6063, 32'h0000_7063, 32'h0000_006F,
        32'h0000_0067, 32'h0000_0037, 32'h0000_0017, 32'hFFFF_FFFF,
        32'h0000_2013, 32'h4000_7033, 32'h0000_0003, 32'h0000_0023,
        32'h0000_2063, 32'h0000_1067, 32'h0000_0000, 32'h0000_1033};
    logic [31:0] t_mask [32] = '{
        RM, RM, RM, RM, RM, RM, RM, IM, IM, IM, IM, IM, IM, IM, IM, IM,
        IM, IM, IM, UM, IM, UM, UM, 32'h0, IM, RM, IM, IM, IM, IM, 32'h0, RM};
    int t_mn [32] = '{
        M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT, M_SLTU, M_ADDI, M_ANDI, M_ORI,
        M_XORI, M_LW, M_SW, M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU, M_JAL,
        M_JALR, M_LUI, M_AUIPC, M_ILL, M_ILL, M_ILL, M_ILL, M_ILL, M_ILL, M_ILL,
        M_ILL, M_ILL};

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req, mem_we, addr_sel, ir_we, mdr_we, aluout_we, pc_we, pc_sel;
        logic [2:0] imm_sel;
        logic       br_un, a_sel, b_sel;
        logic [3:0] alu_sel;
        logic       reg_wen;
        logic [1:0] wb_sel;
        logic       retire, trap;
        logic [1:0] cause;
    } out_t;
    localparam int W = $bits(out_t);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        br_eq = 1'b0, br_lt = 1'b0, mem_ready = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_we, mdr_we, aluout_we, pc_we, pc_sel;
    logic [2:0]  imm_sel;
    logic        br_un, a_sel, b_sel;
    logic [3:0]  alu_sel;
    logic        reg_wen;
    logic [1:0]  wb_sel;
    logic        retire, trap;
    logic [1:0]  cause;
    logic [2:0]  state;

    logic [W-1:0] exp_q [$];
    logic         rdy_q [$];
    int           n_checks = 0;
    int           n_errors = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .br_eq(br_eq), .br_lt(br_lt),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_we(ir_we), .mdr_we(mdr_we), .aluout_we(aluout_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .imm_sel(imm_sel), .br_un(br_un), .a_sel(a_sel), .b_sel(b_sel),
        .alu_sel(alu_sel), .reg_wen(reg_wen), .wb_sel(wb_sel), .retire(retire),
        .trap(trap), .cause(cause), .state(state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic out_t get_obs();
        out_t o;
        o.st = state;          o.mem_req = mem_req;     o.mem_we = mem_we;
        o.addr_sel = addr_sel; o.ir_we = ir_we;         o.mdr_we = mdr_we;
        o.aluout_we = aluout_we; o.pc_we = pc_we;       o.pc_sel = pc_sel;
        o.imm_sel = imm_sel;   o.br_un = br_un;         o.a_sel = a_sel;
        o.b_sel = b_sel;       o.alu_sel = alu_sel;     o.reg_wen = reg_wen;
        o.wb_sel = wb_sel;     o.retire = retire;       o.trap = trap;
        o.cause = cause;
        return o;
    endfunction

    function automatic out_t idle(input logic [2:0] st);
        out_t o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic bit is_branch(input int m);
        return m >= M_BEQ && m <= M_BGEU;
    endfunction

    // Reference EXEC-cycle outputs derived from the mnemonic
    function automatic out_t exec_out(input int m, input logic eq, input logic lt);
        out_t o = idle(3'd2);
        o.aluout_we = 1'b1;
        case (m)
            M_SUB:          o.alu_sel = 4'd1;
            M_AND, M_ANDI:  o.alu_sel = 4'd2;
            M_OR, M_ORI:    o.alu_sel = 4'd3;
            M_XOR, M_XORI:  o.alu_sel = 4'd4;
            M_SLT:          o.alu_sel = 4'd5;
            M_SLTU:         o.alu_sel = 4'd6;
            M_LUI:          o.alu_sel = 4'd7;
            default:        o.alu_sel = 4'd0;
        endcase
        if (m <= M_SLTU)                   o.imm_sel = 3'b101;
        else if (m == M_SW)                o.imm_sel = 3'b001;
        else if (is_branch(m))             o.imm_sel = 3'b010;
        else if (m == M_JAL)               o.imm_sel = 3'b011;
        else if (m == M_LUI || m == M_AUIPC) o.imm_sel = 3'b100;
        else                               o.imm_sel = 3'b000;
        o.a_sel = is_branch(m) || m == M_JAL || m == M_AUIPC;
        o.b_sel = (m > M_SLTU);
        if (is_branch(m)) begin
            o.pc_we  = 1'b1;
            o.retire = 1'b1;
            o.br_un  = (m == M_BLTU || m == M_BGEU);
            case (m)
                M_BEQ:          o.pc_sel = eq;
                M_BNE:          o.pc_sel = !eq;
                M_BLT, M_BLTU:  o.pc_sel = lt;
                default:        o.pc_sel = !lt;
            endcase
        end
        return o;
    endfunction

    task automatic push(input logic rdy, input out_t o);
        rdy_q.push_back(rdy);
        exp_q.push_back(o);
    endtask

    task automatic push_trap(input logic [1:0] c);
        out_t o = idle(3'd7);
        o.trap  = 1'b1;
        o.cause = c;
        for (int i = 0; i < 3; i++) push(1'($urandom_range(0, 1)), o);
    endtask

    // Waiting cycles of a memory access; reports whether it times out
    task automatic add_wait(input logic [2:0] st, input int waits, input logic is_mem,
                            input logic we, input logic [1:0] c, output bit timed_out);
        out_t o = idle(st);
        int n = (waits < TO) ? waits : TO;
        o.mem_req  = 1'b1;
        o.addr_sel = is_mem;
        o.mem_we   = we;
        for (int i = 0; i < n; i++) push(1'b0, o);
        timed_out = (waits >= TO);
        if (timed_out) push_trap(c);
    endtask

    // Expected trace of one instruction; ends_trap set when reset is needed after
    task automatic build(input int m, input int wf, input int wm, input logic eq,
                         input logic lt, output bit ends_trap);
        out_t o;
        bit   to;
        rdy_q.delete();
        exp_q.delete();
        ends_trap = 1'b1;
        add_wait(3'd0, wf, 1'b0, 1'b0, 2'b10, to);
        if (to) return;
        o = idle(3'd0);
        o.mem_req = 1'b1;
        o.ir_we   = 1'b1;
        push(1'b1, o);
        push(1'($urandom_range(0, 1)), idle(3'd1));
        if (m == M_ILL) begin
            push_trap(2'b01);
            return;
        end
        ends_trap = 1'b0;
        push(1'($urandom_range(0, 1)), exec_out(m, eq, lt));
        if (is_branch(m)) return;
        if (m == M_LW || m == M_SW) begin
            add_wait(3'd3, wm, 1'b1, m == M_SW, 2'b11, to);
            if (to) begin
                ends_trap = 1'b1;
                return;
            end
            o = idle(3'd3);
            o.mem_req  = 1'b1;
            o.addr_sel = 1'b1;
            o.mem_we   = (m == M_SW);
            o.mdr_we   = (m == M_LW);
            o.pc_we    = (m == M_SW);
            o.retire   = (m == M_SW);
            push(1'b1, o);
            if (m == M_SW) return;
        end
        o = idle(3'd4);
        o.reg_wen = 1'b1;
        o.pc_we   = 1'b1;
        o.retire  = 1'b1;
        o.pc_sel  = (m == M_JAL || m == M_JALR);
        o.wb_sel  = (m == M_LW) ? 2'b00 : (o.pc_sel ? 2'b10 : 2'b01);
        push(1'($urandom_range(0, 1)), o);
    endtask

    // Reset pulse; outputs checked while held low (mem_req is free)
    task automatic do_reset();
        out_t o;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst_n     = 1'b0;
            mem_ready = 1'b1;
            #2;
            o = get_obs();
            o.mem_req = 1'b0;
            check(i == 0 ? "reset" : "reset_hold", o, idle(3'd0));
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b0;
    endtask

    // Drive one instruction and compare every cycle; cut > 0 aborts with reset
    task automatic run(input logic [31:0] ins, input int m, input int wf, input int wm,
                       input logic eq, input logic lt, input int cut);
        bit           ends_trap;
        int           n;
        logic [W-1:0] e;
        build(m, wf, wm, eq, lt, ends_trap);
        n = (cut > 0 && cut < exp_q.size()) ? cut : exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                instr = ins;
                br_eq = eq;
                br_lt = lt;
            end
            mem_ready = rdy_q.pop_front();
            #2;
            e = exp_q.pop_front();
            check($sformatf("i%08h c%0d", ins, i), get_obs(), e);
        end
        if (ends_trap || cut > 0) do_reset();
    endtask

    initial begin
        int idx, wf, wm;
        logic [31:0] ins;
        do_reset();
        run(32'h0020_81B3, M_ADD,  0, 0, 1'b0, 1'b0, 0);
        run(32'h0080_A283, M_LW,   0, 3, 1'b0, 1'b0, 0);
        run(32'h0020_8463, M_BEQ,  0, 0, 1'b1, 1'b0, 0);
        run(32'h0020_8463, M_BEQ,  0, 0, 1'b0, 1'b0, 0);
        run(32'h0020_E463, M_BLTU, 0, 0, 1'b0, 1'b1, 0);
        run(32'hFFFF_FFFF, M_ILL,  0, 0, 1'b0, 1'b0, 0);
        run(32'h0020_81B3, M_ADD,  4, 0, 1'b0, 1'b0, 0);
        run(32'h0080_A283, M_LW,   0, 4, 1'b0, 1'b0, 0);
        run(32'h0080_A283, M_LW,   3, 3, 1'b0, 1'b0, 0);
        run(32'h0080_A283, M_LW,   0, 3, 1'b0, 1'b0, 5);
        run(32'h0010_A023, M_SW,   1, 2, 1'b0, 1'b0, 0);
        for (int t = 0; t < 300; t++) begin
            idx = $urandom_range(0, 31);
            ins = t_base[idx] | ($urandom() & t_mask[idx]);
            wf  = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
            wm  = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
            run(ins, t_mn[idx], wf, wm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
